alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 125 ++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequencer that drives an external ALU through SETUP/EXEC/READ/DONE and captures its result.
// Optional SQRT support (op 4'b1111) is enabled by defining ALU_SEQ_SQRT_EN.
module alu_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic [3:0] op,
   input  logic [7:0] a_val,
   input  logic [7:0] b_val,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_mode,
   output logic       alu_ee,
   output logic       alu_eo,
   input  logic [7:0] alu_bus,
   input  logic       alu_carry,
   output logic [7:0] result,
   output logic       flag_z,
   output logic       flag_c,
   output logic       busy,
   output logic       ack,
   output logic       err
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_EXEC  = 3'd2;
   localparam logic [2:0] ST_READ  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [3:0] OP_SQRT = 4'b1111;

   logic [2:0] state_reg, state_next;
   logic [7:0] alu_a_reg, alu_b_reg;
   logic [3:0] alu_mode_reg;
   logic       alu_ee_reg, alu_eo_reg;
   logic [7:0] result_reg;
   logic       flag_z_reg, flag_c_reg;
   logic       busy_reg, ack_reg, err_reg;
   logic       op_reject;
   logic       accept, reject;

`ifdef ALU_SEQ_SQRT_EN
   assign op_reject = 1'b0;
`else
   assign op_reject = (op == OP_SQRT);
`endif

   assign accept = (state_reg == ST_IDLE) && req && !op_reject;
   assign reject = (state_reg == ST_IDLE) && req && op_reject;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept)
               state_next = ST_SETUP;
            else if (reject)
               state_next = ST_DONE;
         end
         ST_SETUP: state_next = ST_EXEC;
         ST_EXEC:  state_next = ST_READ;
         ST_READ:  state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Strobes are registered from the next state so they line up exactly with the state they belong to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         alu_ee_reg <= 1'b0;
         alu_eo_reg <= 1'b0;
         busy_reg   <= 1'b0;
         ack_reg    <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         alu_ee_reg <= (state_next == ST_EXEC);
         alu_eo_reg <= (state_next == ST_READ);
         busy_reg   <= (state_next != ST_IDLE);
         ack_reg    <= (state_next == ST_DONE);
         err_reg    <= reject;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a_reg    <= 8'h00;
         alu_b_reg    <= 8'h00;
         alu_mode_reg <= 4'h0;
      end else if (accept) begin
         alu_a_reg    <= a_val;
         alu_b_reg    <= b_val;
         alu_mode_reg <= op;
      end
   end

   // Zero is derived from the sampled bus; the ALU's own zero flag is one evaluation stale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_reg <= 8'h00;
         flag_z_reg <= 1'b0;
         flag_c_reg <= 1'b0;
      end else if (state_reg == ST_READ) begin
         result_reg <= alu_bus;
         flag_z_reg <= (alu_bus == 8'h00);
         flag_c_reg <= alu_carry;
      end
   end

   assign alu_a    = alu_a_reg;
   assign alu_b    = alu_b_reg;
   assign alu_mode = alu_mode_reg;
   assign alu_ee   = alu_ee_reg;
   assign alu_eo   = alu_eo_reg;
   assign result   = result_reg;
   assign flag_z   = flag_z_reg;
   assign flag_c   = flag_c_reg;
   assign busy     = busy_reg;
   assign ack      = ack_reg;
   assign err      = err_reg;

endmodule
